// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler
//   Sequences Game of Life generation updates. At the start of vertical
//   blanking it launches a generation when one is due, streams every cell
//   index to the update engine over a valid/ready handshake, waits for the
//   engine to drain, then swaps the front/back cell buffers.
//
//   Optional feature (macro LIFE_SCHED_CLEAR_EN): adds a grid clear pass.
//   A clear request runs a full scan with cell_clear=1. It toggles buf_sel
//   but does not count as a generation.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   frame_start     pulse at start of vertical blanking
//   run             level, free-running generations
//   step            pulse, single generation request while run=0
//   clear_overrun   pulse, clears the sticky overrun flag
//   clear           (LIFE_SCHED_CLEAR_EN) pulse, request a clear pass
//   cell_clear      (LIFE_SCHED_CLEAR_EN) current pass writes zeros
//   cell_valid/cell_ready/cell_row/cell_col  cell index stream to engine
//   engine_busy     engine still has writes in flight
//   buf_sel         front buffer select (display reads this one)
//   gen_count       completed generations, wraps
//   busy            scheduler not IDLE
//   overrun         sticky, frame_start seen while not IDLE
//
// state  | meaning
// IDLE   | waiting for a frame_start that launches a pass
// ISSUE  | presenting cell indices row-major to the engine
// DRAIN  | waiting for engine_busy to fall
// SWAP   | one cycle: toggle buf_sel, count the generation
module life_gen_scheduler #(
    parameter int GRID_W         = 14,
    parameter int GRID_H         = 14,
    parameter int COL_W          = 5,
    parameter int ROW_W          = 5,
    parameter int FRAMES_PER_GEN = 8,
    parameter int GEN_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             run,
    input  logic             step,
    input  logic             clear_overrun,
`ifdef LIFE_SCHED_CLEAR_EN
    input  logic             clear,
    output logic             cell_clear,
`endif
    output logic             cell_valid,
    input  logic             cell_ready,
    output logic [ROW_W-1:0] cell_row,
    output logic [COL_W-1:0] cell_col,
    input  logic             engine_busy,
    output logic             buf_sel,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             overrun
);

    localparam int FC_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_GEN - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_H - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SWAP} state_t;

    state_t           state, state_d;
    logic [FC_W-1:0]  frame_cnt, frame_cnt_d;
    logic             step_pending, step_pending_d;
    logic             cell_valid_d;
    logic [ROW_W-1:0] cell_row_d;
    logic [COL_W-1:0] cell_col_d;
    logic             buf_sel_d;
    logic [GEN_W-1:0] gen_count_d;
    logic             busy_d;
    logic             overrun_d;
    logic             step_req;
    logic             clear_go;
`ifdef LIFE_SCHED_CLEAR_EN
    logic             clear_pending, clear_pending_d;
    logic             cell_clear_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            step_pending <= 1'b0;
            cell_valid   <= 1'b0;
            cell_row     <= '0;
            cell_col     <= '0;
            buf_sel      <= 1'b0;
            gen_count    <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
`ifdef LIFE_SCHED_CLEAR_EN
            clear_pending <= 1'b0;
            cell_clear    <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            frame_cnt    <= frame_cnt_d;
            step_pending <= step_pending_d;
            cell_valid   <= cell_valid_d;
            cell_row     <= cell_row_d;
            cell_col     <= cell_col_d;
            buf_sel      <= buf_sel_d;
            gen_count    <= gen_count_d;
            busy         <= busy_d;
            overrun      <= overrun_d;
`ifdef LIFE_SCHED_CLEAR_EN
            clear_pending <= clear_pending_d;
            cell_clear    <= cell_clear_d;
`endif
        end
    end

    always_comb begin
        state_d        = state;
        frame_cnt_d    = frame_cnt;
        step_pending_d = step_pending;
        cell_valid_d   = cell_valid;
        cell_row_d     = cell_row;
        cell_col_d     = cell_col;
        buf_sel_d      = buf_sel;
        gen_count_d    = gen_count;
        overrun_d      = overrun;
        step_req       = step && !run;
`ifdef LIFE_SCHED_CLEAR_EN
        clear_pending_d = clear_pending || clear;
        cell_clear_d    = cell_clear;
        clear_go        = clear_pending || clear;
`else
        clear_go        = 1'b0;
`endif

        if (step_req) begin
            step_pending_d = 1'b1;
        end

        // Set has priority over clear when both land in the same cycle.
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        if (frame_start && (state != IDLE)) begin
            overrun_d = 1'b1;
        end

        if (!run) begin
            frame_cnt_d = '0;
        end

        case (state)
            IDLE: begin
                if (frame_start) begin
                    if (clear_go) begin
                        // Clear pass leaves any latched step waiting.
                        state_d      = ISSUE;
                        cell_valid_d = 1'b1;
                        frame_cnt_d  = '0;
`ifdef LIFE_SCHED_CLEAR_EN
                        clear_pending_d = 1'b0;
                        cell_clear_d    = 1'b1;
`endif
                    end else if ((run && (frame_cnt == FC_LAST)) || step_pending || step_req) begin
                        state_d        = ISSUE;
                        cell_valid_d   = 1'b1;
                        frame_cnt_d    = '0;
                        step_pending_d = 1'b0;
                    end else if (run) begin
                        frame_cnt_d = frame_cnt + 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (cell_valid && cell_ready) begin
                    if (cell_col == COL_LAST) begin
                        cell_col_d = '0;
                        if (cell_row == ROW_LAST) begin
                            cell_row_d   = '0;
                            cell_valid_d = 1'b0;
                            state_d      = DRAIN;
                        end else begin
                            cell_row_d = cell_row + 1'b1;
                        end
                    end else begin
                        cell_col_d = cell_col + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!engine_busy) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                buf_sel_d = ~buf_sel;
                state_d   = IDLE;
`ifdef LIFE_SCHED_CLEAR_EN
                if (!cell_clear) begin
                    gen_count_d = gen_count + 1'b1;
                end
                cell_clear_d = 1'b0;
`else
                gen_count_d = gen_count + 1'b1;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed testbench for life_gen_scheduler (default parameters, 14x14 grid,
// FRAMES_PER_GEN=8). Build with LIFE_SCHED_CLEAR_EN to include the clear pass.
module tb_life_gen_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        cell_valid;
    logic        cell_ready = 1'b1;
    logic [4:0]  cell_row;
    logic [4:0]  cell_col;
    logic        engine_busy = 1'b0;
    logic        buf_sel;
    logic [15:0] gen_count;
    logic        busy;
    logic        overrun;
`ifdef LIFE_SCHED_CLEAR_EN
    logic        clear = 1'b0;
    logic        cell_clear;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    life_gen_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .run           (run),
        .step          (step),
        .clear_overrun (clear_overrun),
`ifdef LIFE_SCHED_CLEAR_EN
        .clear         (clear),
        .cell_clear    (cell_clear),
`endif
        .cell_valid    (cell_valid),
        .cell_ready    (cell_ready),
        .cell_row      (cell_row),
        .cell_col      (cell_col),
        .engine_busy   (engine_busy),
        .buf_sel       (buf_sel),
        .gen_count     (gen_count),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Drives cell_ready through one pass. Stalls sn cycles at (sr,sc).
    // Reports handshakes, index-order errors and stall cycles observed.
    task automatic scan(input int sr, input int sc, input int sn,
                        output int hs, output int bad_idx, output int stalls);
        int er = 0;
        int ec = 0;
        int budget = 0;
        hs = 0;
        bad_idx = 0;
        stalls = 0;
        while (hs < 196 && budget < 2000) begin
            if (cell_valid) begin
                if (cell_row !== 5'(er) || cell_col !== 5'(ec)) bad_idx++;
                if (er == sr && ec == sc && stalls < sn) begin
                    cell_ready = 1'b0;
                    stalls++;
                end else begin
                    cell_ready = 1'b1;
                    hs++;
                    if (ec == 13) begin
                        ec = 0;
                        er++;
                    end else begin
                        ec++;
                    end
                end
            end else begin
                cell_ready = 1'b1;
            end
            tick();
            budget++;
        end
        cell_ready = 1'b1;
    endtask

    task automatic test_reset();
        int busy_seen = 0;
        do_reset();
        total++;
        if ({cell_valid, cell_row, cell_col, buf_sel, gen_count, busy, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0d r=%0d c=%0d b=%0d g=%0d busy=%0d ov=%0d want all 0",
                     cell_valid, cell_row, cell_col, buf_sel, gen_count, busy, overrun);
        end
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_frame();
            if (busy) busy_seen++;
            tick();
            if (busy) busy_seen++;
        end
        total++;
        if (busy_seen != 0) begin
            bad++;
            $display("FAIL idle_busy: busy seen %0d cycles want 0", busy_seen);
        end
        total++;
        if (overrun !== 1'b0 || cell_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_outputs: ov=%0d v=%0d want 0 0", overrun, cell_valid);
        end
    endtask

    task automatic test_free_run();
        int hs, bi, st;
        int early = 0;
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            pulse_frame();
            if (busy) early++;
            tick();
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL free_early_launch: launches %0d want 0", early);
        end
        pulse_frame();
        total++;
        if (busy !== 1'b1 || cell_valid !== 1'b1 || cell_row !== 5'd0 || cell_col !== 5'd0) begin
            bad++;
            $display("FAIL free_launch8: busy=%0d v=%0d r=%0d c=%0d want 1 1 0 0",
                     busy, cell_valid, cell_row, cell_col);
        end
        scan(-1, -1, 0, hs, bi, st);
        total++;
        if (hs != 196 || bi != 0) begin
            bad++;
            $display("FAIL free_scan: handshakes=%0d order_errs=%0d want 196 0", hs, bi);
        end
        total++;
        if (cell_valid !== 1'b0) begin
            bad++;
            $display("FAIL free_valid_drop: v=%0d want 0", cell_valid);
        end
        tick();
        tick();
        total++;
        if (buf_sel !== 1'b1 || gen_count !== 16'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL free_swap1: buf=%0d gen=%0d busy=%0d want 1 1 0", buf_sel, gen_count, busy);
        end
        early = 0;
        for (int i = 9; i <= 15; i++) begin
            pulse_frame();
            if (busy) early++;
            tick();
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL free_early_launch2: launches %0d want 0", early);
        end
        pulse_frame();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL free_launch16: busy=%0d want 1", busy);
        end
        scan(-1, -1, 0, hs, bi, st);
        tick();
        tick();
        total++;
        if (hs != 196 || buf_sel !== 1'b0 || gen_count !== 16'd2) begin
            bad++;
            $display("FAIL free_swap2: hs=%0d buf=%0d gen=%0d want 196 0 2", hs, buf_sel, gen_count);
        end
        run = 1'b0;
    endtask

    task automatic test_backpressure();
        int hs, bi, st;
        do_reset();
        step = 1'b1;
        tick();
        step = 1'b0;
        pulse_frame();
        scan(2, 5, 3, hs, bi, st);
        total++;
        if (hs != 196 || bi != 0 || st != 3) begin
            bad++;
            $display("FAIL backpressure: hs=%0d order_errs=%0d stalls=%0d want 196 0 3", hs, bi, st);
        end
        tick();
        tick();
        total++;
        if (gen_count !== 16'd1 || buf_sel !== 1'b1) begin
            bad++;
            $display("FAIL bp_swap: gen=%0d buf=%0d want 1 1", gen_count, buf_sel);
        end
    endtask

    task automatic test_step_drain();
        int hs, bi, st;
        int early_swap = 0;
        do_reset();
        run = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL step_no_launch: busy=%0d want 0", busy);
        end
        pulse_frame();
        scan(-1, -1, 0, hs, bi, st);
        engine_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (buf_sel !== 1'b0 || gen_count !== 16'd0 || busy !== 1'b1) early_swap++;
        end
        total++;
        if (early_swap != 0) begin
            bad++;
            $display("FAIL drain_hold: early swaps %0d want 0", early_swap);
        end
        engine_busy = 1'b0;
        tick();
        total++;
        if (buf_sel !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL drain_to_swap: buf=%0d busy=%0d want 0 1", buf_sel, busy);
        end
        tick();
        total++;
        if (buf_sel !== 1'b1 || gen_count !== 16'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL step_swap: buf=%0d gen=%0d busy=%0d want 1 1 0", buf_sel, gen_count, busy);
        end
        pulse_frame();
        tick();
        total++;
        if (busy !== 1'b0 || gen_count !== 16'd1) begin
            bad++;
            $display("FAIL step_once: busy=%0d gen=%0d want 0 1", busy, gen_count);
        end
    endtask

    task automatic test_overrun_reset();
        int hs, bi, st;
        do_reset();
        cell_ready = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        pulse_frame();
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ov_launch: ov=%0d want 0", overrun);
        end
        pulse_frame();
        tick();
        tick();
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ov_set: ov=%0d want 1", overrun);
        end
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ov_clear: ov=%0d want 0", overrun);
        end
        clear_overrun = 1'b1;
        frame_start = 1'b1;
        tick();
        clear_overrun = 1'b0;
        frame_start = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ov_set_wins: ov=%0d want 1", overrun);
        end
        scan(-1, -1, 0, hs, bi, st);
        total++;
        if (hs != 196 || bi != 0) begin
            bad++;
            $display("FAIL ov_scan: hs=%0d order_errs=%0d want 196 0", hs, bi);
        end
        engine_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || buf_sel !== 1'b0 || gen_count !== 16'd0 || overrun !== 1'b0 || cell_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: busy=%0d buf=%0d gen=%0d ov=%0d v=%0d want all 0",
                     busy, buf_sel, gen_count, overrun, cell_valid);
        end
        tick();
        rst = 1'b0;
        engine_busy = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || buf_sel !== 1'b0 || gen_count !== 16'd0) begin
            bad++;
            $display("FAIL post_reset: busy=%0d buf=%0d gen=%0d want 0 0 0", busy, buf_sel, gen_count);
        end
    endtask

`ifdef LIFE_SCHED_CLEAR_EN
    task automatic test_clear();
        int hs, bi, st;
        do_reset();
        run = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_wait: busy=%0d want 0", busy);
        end
        pulse_frame();
        total++;
        if (busy !== 1'b1 || cell_clear !== 1'b1) begin
            bad++;
            $display("FAIL clear_launch: busy=%0d cell_clear=%0d want 1 1", busy, cell_clear);
        end
        scan(-1, -1, 0, hs, bi, st);
        total++;
        if (hs != 196 || bi != 0 || cell_clear !== 1'b1) begin
            bad++;
            $display("FAIL clear_scan: hs=%0d order_errs=%0d cell_clear=%0d want 196 0 1", hs, bi, cell_clear);
        end
        tick();
        tick();
        total++;
        if (buf_sel !== 1'b1 || gen_count !== 16'd0 || cell_clear !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_swap: buf=%0d gen=%0d cell_clear=%0d busy=%0d want 1 0 0 0",
                     buf_sel, gen_count, cell_clear, busy);
        end
        run = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_step_drain();
        test_overrun_reset();
`ifdef LIFE_SCHED_CLEAR_EN
        test_clear();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_gen_scheduler.md
Name: life_gen_scheduler

Overview:
- Sequences Game of Life generation updates over the cell grid.
- At the start of vertical blanking, launches a generation when it is due. It then scans every cell index to the update engine over a valid/ready handshake, waits for the engine to drain, and swaps the front/back cell buffers.
- The display path reads the buffer selected by buf_sel. The engine reads buf_sel and writes ~buf_sel.

Parameters:
- GRID_W, 14, grid columns (cells per row)
- GRID_H, 14, grid rows
- COL_W, 5, width of cell_col
- ROW_W, 5, width of cell_row
- FRAMES_PER_GEN, 8, frame_start pulses per generation while running (>=1)
- GEN_W, 16, width of gen_count

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- run  in  1  level; free-running generations
- step  in  1  one-cycle pulse; request one generation while run=0
- clear_overrun  in  1  one-cycle pulse; clears overrun
- cell_valid  out  1  cell index presented to engine
- cell_ready  in  1  engine accepts current index
- cell_row  out  ROW_W  row of presented cell
- cell_col  out  COL_W  column of presented cell
- engine_busy  in  1  engine still has writes in flight
- buf_sel  out  1  front buffer select (display reads this one)
- gen_count  out  GEN_W  completed generations, wraps
- busy  out  1  scheduler not IDLE
- overrun  out  1  sticky; frame_start arrived while not IDLE

Behaviour:
- Reset values (async, all outputs registered):
  - cell_valid=0, cell_row=0, cell_col=0, buf_sel=0, gen_count=0, busy=0, overrun=0
  - state=IDLE, frame_cnt=0, step_pending=0
- Reset mid-generation aborts immediately. No swap occurs and no count is made.
- FSM states: IDLE, ISSUE, DRAIN, SWAP.
- IDLE:
  - step while run=0 sets step_pending. step while run=1 is ignored.
  - On frame_start, launch if (run && frame_cnt==FRAMES_PER_GEN-1), or step_pending, or (step && !run) in the same cycle.
  - On launch: frame_cnt<=0, step_pending<=0, go to ISSUE.
  - Otherwise, on frame_start with run=1: frame_cnt<=frame_cnt+1.
  - run=0 holds frame_cnt at 0.
  - With FRAMES_PER_GEN=1, every frame_start while running launches.
- ISSUE:
  - First cycle after launch: cell_valid=1, row=0, col=0.
  - Indices are unchanged while cell_valid && !cell_ready.
  - On handshake, advance row-major: col+1. At col==GRID_W-1, col<=0 and row+1.
  - Handshake on (GRID_H-1, GRID_W-1): cell_valid<=0, row/col<=0, go to DRAIN.
  - With cell_ready tied high, exactly GRID_W*GRID_H valid cycles.
- DRAIN: stay while engine_busy=1. When engine_busy=0, go to SWAP. The check happens no earlier than the cycle after the last handshake.
- SWAP: one cycle. buf_sel<=~buf_sel, gen_count<=gen_count+1 (wraps modulo 2^GEN_W), go to IDLE.
- busy<=1 on the cycle state leaves IDLE. busy<=0 on return to IDLE (registered, aligned with state).
- run dropped mid-generation: the current generation completes. No further launches occur.
- step during ISSUE/DRAIN/SWAP: latched into step_pending if run=0. It is serviced at a later frame_start.
- frame_start in ISSUE/DRAIN/SWAP: overrun<=1. Not counted toward frame_cnt, never launches.
- clear_overrun: overrun<=0. If it coincides with a new overrun event, set wins.

Optional Feature:
- Macro: LIFE_SCHED_CLEAR_EN.
- When defined:
  - Adds input clear (pulse) and output cell_clear (1).
  - clear in IDLE or pending is latched (clear_pending). On the next frame_start it launches with priority over run/step.
  - It performs the full ISSUE/DRAIN/SWAP scan with cell_clear=1 for the whole pass; the engine writes 0.
  - SWAP toggles buf_sel but does NOT increment gen_count. frame_cnt<=0.
  - A step latched alongside clear remains pending.
- When undefined: ports are absent and behaviour is exactly as above.

Test Plan:
- Reset then idle: rst pulse, run=0, 3 frame_start pulses.
  - Required: all outputs 0, busy never rises, overrun=0.
- Free run, FRAMES_PER_GEN=8, ready=1, busy low:
  - The 8th frame_start launches 196 valid cycles, (0,0)..(13,13) row-major.
  - Then SWAP: buf_sel 0->1, gen_count=1. Next launch at the 16th pulse.
- Backpressure: cell_ready low 3 cycles at index (2,5).
  - Required: row=2, col=5 stable for all 3 cycles. Total handshakes still 196. No index skipped or repeated.
- Step and drain: run=0, step pulse, then frame_start, engine_busy held 10 cycles after the last handshake.
  - Required: DRAIN lasts 10 cycles, one swap, gen_count=1.
  - A second frame_start with no new step does nothing.
- Overrun and mid-op reset: frame_start during ISSUE.
  - Required: overrun=1 until clear_overrun.
  - rst asserted during DRAIN: immediate return to reset values, buf_sel unchanged from 0, gen_count=0.
- LIFE_SCHED_CLEAR_EN, run=1, clear pulse:
  - Next frame_start runs a 196-cell pass with cell_clear=1.
  - buf_sel toggles, gen_count unchanged.
